// File: rtl/nbit_serial_adder.sv
// ---------------------------------------------------------------------------------------------
// nbit_serial_adder
//   Digit-serial N-bit adder computing S = A + B + CI, least-significant digit first, W bits per
//   clock. Operands are taken on an in_valid/in_ready handshake and the result is held on
//   out_valid/out_ready until consumed. Result latency is N/W cycles after the accepting edge.
//
// Parameters
//   N  operand/result width (bits)
//   W  digit width per cycle; must satisfy 1 <= W <= N and N % W == 0
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        asynchronous active-high reset
//   in_valid_i   operands a_i/b_i/ci_i valid
//   in_ready_o   block can accept operands (IDLE only)
//   a_i, b_i     addends (two's complement when overflow detection is built in)
//   ci_i         carry in
//   out_valid_o  s_o/co_o/ovf_o hold a completed result
//   out_ready_i  consumer takes the result
//   s_o          sum mod 2^N
//   co_o         carry out of bit N-1
//   ovf_o        signed overflow; present only when SERIAL_ADD_OVF_EN is defined
//
// Build option
//   SERIAL_ADD_OVF_EN  adds the ovf_o port and the operand sign capture behind it.
// ---------------------------------------------------------------------------------------------
module nbit_serial_adder #(
    parameter int unsigned N = 8,
    parameter int unsigned W = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         ci_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [N-1:0] s_o,
    output logic         co_o
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic         ovf_o
`endif
);

    // Guard the modulo against W == 0 so the check itself elaborates cleanly.
    if ((W == 0) || (W > N) || ((N % ((W == 0) ? 1 : W)) != 0)) begin : g_bad_param
        $error("nbit_serial_adder: W must satisfy 1 <= W <= N and N %% W == 0");
    end

    localparam int unsigned Digits = (W == 0) ? 1 : N / W;
    localparam int unsigned CntW   = (Digits > 1) ? $clog2(Digits) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          state_q;
    logic [N-1:0]    a_sh_q, b_sh_q;
    logic            carry_q;
    logic [CntW-1:0] cnt_q;
    logic [N-1:0]    s_q;
    logic            co_q;
    logic            in_ready_q;
    logic            out_valid_q;

    logic [W:0]      digit_sum;
    logic [N-1:0]    sum_d;
    logic            last_digit;

    always_comb begin
        digit_sum  = {1'b0, a_sh_q[W-1:0]} + {1'b0, b_sh_q[W-1:0]} + (W + 1)'(carry_q);
        last_digit = (cnt_q == CntW'(Digits - 1));
    end

    // Partial sum: earlier digits sit in acc_q; the current digit enters at the MSB end, so on
    // the last digit sum_d is the complete result in its final bit positions.
    if (W < N) begin : g_acc
        logic [N-W-1:0] acc_q;

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                acc_q <= '0;
            end else if (state_q == StRun) begin
                acc_q <= sum_d[N-1:W];
            end
        end

        assign sum_d = {digit_sum[W-1:0], acc_q};
    end else begin : g_no_acc
        assign sum_d = digit_sum[W-1:0];
    end

`ifdef SERIAL_ADD_OVF_EN
    logic a_sign_q, b_sign_q, ovf_q;
    logic ovf_d;

    always_comb begin
        ovf_d = (a_sign_q == b_sign_q) && (sum_d[N-1] != a_sign_q);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_sign_q <= 1'b0;
            b_sign_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else if ((state_q == StIdle) && in_valid_i && in_ready_q) begin
            a_sign_q <= a_i[N-1];
            b_sign_q <= b_i[N-1];
        end else if ((state_q == StRun) && last_digit) begin
            ovf_q    <= ovf_d;
        end
    end

    assign ovf_o = ovf_q;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            s_q         <= '0;
            co_q        <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid_i && in_ready_q) begin
                        a_sh_q     <= a_i;
                        b_sh_q     <= b_i;
                        carry_q    <= ci_i;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= StRun;
                    end
                end
                StRun: begin
                    a_sh_q  <= a_sh_q >> W;
                    b_sh_q  <= b_sh_q >> W;
                    carry_q <= digit_sum[W];
                    cnt_q   <= cnt_q + CntW'(1);
                    if (last_digit) begin
                        s_q         <= sum_d;
                        co_q        <= digit_sum[W];
                        out_valid_q <= 1'b1;
                        state_q     <= StDone;
                    end
                end
                StDone: begin
                    // in_ready returns only after this edge, so no same-cycle re-accept.
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign s_o         = s_q;
    assign co_o        = co_q;

endmodule

// File: tb/tb_nbit_serial_adder.sv
// ---------------------------------------------------------------------------------------------
// tb_nbit_serial_adder
//   Drives one W=1 and one W=4 instance (N=8) from shared operands. Each accepted operand set
//   pushes its arithmetic result onto a per-instance queue; a negedge monitor pops and compares
//   on every result, and also checks latency, hold-while-stalled and retention after handshake.
// ---------------------------------------------------------------------------------------------
module tb_nbit_serial_adder;

    localparam int unsigned N = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         out_ready;
    logic [N-1:0] a, b;
    logic         ci;

    logic         rdy0, rdy1, ov0, ov1, co0, co1, of0, of1;
    logic [N-1:0] s0, s1;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    nbit_serial_adder #(.N(N), .W(1)) u_dut_w1 (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (rdy0),
        .a_i         (a),
        .b_i         (b),
        .ci_i        (ci),
        .out_valid_o (ov0),
        .out_ready_i (out_ready),
        .s_o         (s0),
        .co_o        (co0)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .ovf_o       (of0)
`endif
    );

    nbit_serial_adder #(.N(N), .W(4)) u_dut_w4 (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (rdy1),
        .a_i         (a),
        .b_i         (b),
        .ci_i        (ci),
        .out_valid_o (ov1),
        .out_ready_i (out_ready),
        .s_o         (s1),
        .co_o        (co1)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .ovf_o       (of1)
`endif
    );

`ifndef SERIAL_ADD_OVF_EN
    assign of0 = 1'b0;
    assign of1 = 1'b0;
`endif

    typedef struct {
        logic [N-1:0] s;
        logic         co;
        logic         ovf;
        int           acc;
    } exp_t;

    exp_t         q0[$];
    exp_t         q1[$];
    int           lat[2] = '{8, 2};
    logic [N-1:0] held_s[2];
    logic         held_co[2];
    logic         held_of[2];
    logic         prev_ov[2];
    int           n_chk = 0;
    int           n_fail = 0;
    bit           mon_en = 1'b0;
    bit           rand_ready = 1'b0;

    task automatic check(input string name, input int id, input logic [31:0] act,
                         input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0d required %0d (t=%0t)", name, id, act, req, $time);
        end
    endtask

    task automatic mon(input int id, input logic v, input logic r, input logic [N-1:0] sv,
                       input logic cv, input logic ofv);
        exp_t e;
        int   qs;
        qs = (id == 0) ? q0.size() : q1.size();
        if (v) begin
            check("in_ready_low_in_done", id, 32'(r), 0);
            if (!prev_ov[id]) begin
                if (qs == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL spurious_out_valid dut%0d: got out_valid=1 required 0", id);
                end else begin
                    if (id == 0) e = q0[0];
                    else e = q1[0];
                    check("latency", id, 32'(cyc - e.acc), 32'(lat[id]));
                    check("sum", id, 32'(sv), 32'(e.s));
                    check("carry_out", id, 32'(cv), 32'(e.co));
`ifdef SERIAL_ADD_OVF_EN
                    check("overflow", id, 32'(ofv), 32'(e.ovf));
`endif
                    held_s[id]  = e.s;
                    held_co[id] = e.co;
                    held_of[id] = e.ovf;
                end
            end else begin
                check("hold_sum", id, 32'(sv), 32'(held_s[id]));
                check("hold_co", id, 32'(cv), 32'(held_co[id]));
            end
            if (out_ready && qs > 0) begin
                if (id == 0) void'(q0.pop_front());
                else void'(q1.pop_front());
            end
        end else begin
            check("retain_sum", id, 32'(sv), 32'(held_s[id]));
            check("retain_co", id, 32'(cv), 32'(held_co[id]));
`ifdef SERIAL_ADD_OVF_EN
            check("retain_ovf", id, 32'(ofv), 32'(held_of[id]));
`endif
        end
        prev_ov[id] = v;
    endtask

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            mon(0, ov0, rdy0, s0, co0, of0);
            mon(1, ov1, rdy1, s1, co1, of1);
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Called 1 time unit after a rising edge; reset is raised and dropped mid-cycle.
    task automatic do_reset();
        #2;
        rst = 1'b1;
        q0.delete();
        q1.delete();
        for (int i = 0; i < 2; i++) begin
            held_s[i]  = '0;
            held_co[i] = 1'b0;
            held_of[i] = 1'b0;
            prev_ov[i] = 1'b0;
        end
        #1;
        check("reset_in_ready", 0, 32'(rdy0), 1);
        check("reset_out_valid", 0, 32'(ov0), 0);
        check("reset_sum", 0, 32'(s0), 0);
        check("reset_co", 0, 32'(co0), 0);
        check("reset_in_ready", 1, 32'(rdy1), 1);
        check("reset_out_valid", 1, 32'(ov1), 0);
        check("reset_sum", 1, 32'(s1), 0);
        check("reset_co", 1, 32'(co1), 0);
`ifdef SERIAL_ADD_OVF_EN
        check("reset_ovf", 0, 32'(of0), 0);
        check("reset_ovf", 1, 32'(of1), 0);
`endif
        @(posedge clk);
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [N-1:0] av, input logic [N-1:0] bv, input logic cv);
        exp_t     e;
        logic [N:0] full;
        int       sa, sb, ssum;
        int       t = 0;
        while (!(rdy0 && rdy1) && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 200) begin
            n_chk++;
            n_fail++;
            $display("FAIL issue_timeout: got in_ready=%0b%0b required 11", rdy0, rdy1);
            return;
        end
        in_valid = 1'b1;
        a        = av;
        b        = bv;
        ci       = cv;
        full     = {1'b0, av} + {1'b0, bv} + (N + 1)'(cv);
        sa       = $signed(av);
        sb       = $signed(bv);
        ssum     = sa + sb + int'(cv);
        e.s      = full[N-1:0];
        e.co     = full[N];
        e.ovf    = (ssum > 127) || (ssum < -128);
        @(posedge clk);
        #1;
        e.acc = cyc;
        q0.push_back(e);
        q1.push_back(e);
        check("in_ready_after_accept", 0, 32'(rdy0), 0);
        check("in_ready_after_accept", 1, 32'(rdy1), 0);
        in_valid = 1'b0;
        a        = N'($urandom);
        b        = N'($urandom);
        ci       = 1'($urandom);
    endtask

    task automatic drain();
        int t = 0;
        while ((q0.size() != 0 || q1.size() != 0) && t < 500) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 500) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d/%0d pending required 0/0", q0.size(), q1.size());
        end
    endtask

    initial begin
        int t;
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        ci        = 1'b0;
        @(posedge clk);
        #1;
        do_reset();
        mon_en = 1'b1;

        issue(8'd10, 8'd15, 1'b0);
        drain();
        issue(8'd255, 8'd1, 1'b0);
        issue(8'd127, 8'd1, 1'b0);
        drain();
        issue(8'd200, 8'd100, 1'b1);
        drain();

        // Stall in DONE while offering new operands that must be ignored.
        out_ready = 1'b0;
        issue(8'd3, 8'd5, 1'b1);
        t = 0;
        while (!ov0 && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("reach_done", 0, 32'(ov0), 1);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            a        = 8'd1;
            b        = 8'd1;
            ci       = 1'b0;
            @(posedge clk);
            #1;
            check("bp_out_valid", 0, 32'(ov0), 1);
            check("bp_in_ready", 0, 32'(rdy0), 0);
            check("bp_sum", 0, 32'(s0), 9);
            check("bp_out_valid", 1, 32'(ov1), 1);
            check("bp_sum", 1, 32'(s1), 9);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_valid", 0, 32'(ov0), 0);
        check("bp_release_ready", 0, 32'(rdy0), 1);
        check("bp_release_ready", 1, 32'(rdy1), 1);
        check("bp_pending", 0, 32'(q0.size()), 0);
        repeat (10) @(posedge clk);
        #1;

        // Abort mid-computation: nothing from the aborted operation may appear.
        issue(8'd200, 8'd100, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        do_reset();
        issue(8'd3, 8'd4, 1'b1);
        drain();

        rand_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            issue(N'($urandom), N'($urandom), 1'($urandom));
        end
        drain();
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
